data_mem_bytelane: RTL
======================

DATA_MEM_BYTELANE -- requirements
Module: data_mem_bytelane

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning memory depth in 32-bit words; a power of 2, >= 4; AW = log2(DEPTH).
REQ-002 SHALL have parameter INIT_ZERO, default 1, meaning 1 = zero every word after reset, 0 = contents preserved across reset.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Clk  in  1  rising-edge clock.
REQ-005 SHALL have port Rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port Req_valid  in  1  request present.
REQ-007 SHALL have port Req_ready  out  1  block can accept a request.
REQ-008 SHALL have port Wr_en  in  1  1 = store, 0 = load.
REQ-009 SHALL have port Size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port Unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored on stores.
REQ-011 SHALL have port Addr  in  32  byte address.
REQ-012 SHALL have port Data_in  in  32  store data, right-aligned.
REQ-013 SHALL have port Rsp_valid  out  1  one-cycle response strobe.
REQ-014 SHALL have port Data_out  out  32  load result, right-aligned and extended.
REQ-015 SHALL have port Err  out  1  misaligned or illegal access, valid with Rsp_valid.

Function
REQ-016 SHALL accept a request on a rising edge where Req_valid=1 and Req_ready=1; at most one request per cycle.
REQ-017 SHALL index words with Addr[AW+1:2] and ignore Addr[31:AW+2] (aliasing).
REQ-018 SHALL implement states INIT and RUN; Req_ready=1 only in RUN.
REQ-019 INIT (INIT_ZERO=1) SHALL write 0 to one word per cycle, counter 0..DEPTH-1, and enter RUN after word DEPTH-1 (DEPTH cycles).
REQ-020 With INIT_ZERO=0, reset SHALL enter RUN directly and leave array contents untouched.
REQ-021 SHALL treat as error: Size=11; Size=01 with Addr[0]=1; Size=10 with Addr[1:0]!=00.
REQ-022 Store, no error: Size=00 SHALL write Data_in[7:0] to byte lane Addr[1:0] only; Size=01 writes Data_in[15:0] to lanes {Addr[1],0}..{Addr[1],1}; Size=10 writes all 4 lanes; other lanes unchanged; write commits at the accept edge.
REQ-023 Load, no error: SHALL read the addressed word at the accept edge, extract the byte, half or word by Addr[1:0], and sign- or zero-extend per Unsigned.
REQ-024 SHALL assert Rsp_valid for exactly one cycle, the cycle after each accept (latency 1), for loads and stores; there is no response backpressure.
REQ-025 Store responses SHALL drive Data_out=0 and Err=0 on a legal store.
REQ-026 Error responses SHALL drive Err=1 and Data_out=0, with no array write.
REQ-027 When Rsp_valid=0, Err SHALL be 0 and Data_out SHALL hold its last value.
REQ-028 A load accepted the cycle after a store to the same word SHALL return the newly stored data; back-to-back requests sustain 1 per cycle.
REQ-029 Little-endian: lane 0 = bits [7:0] of a word.

Reset
REQ-030 Rst=1 at a rising edge SHALL force Rsp_valid=0, Err=0, Data_out=0, and the INIT counter to 0.
REQ-031 Next state after reset SHALL be INIT if INIT_ZERO=1, else RUN; Req_ready=0 while in INIT and during the Rst=1 cycles.
REQ-032 Rst asserted during INIT SHALL restart the sweep at word 0.
REQ-033 Rst asserted in RUN SHALL discard any pending response (no Rsp_valid the following cycle).
REQ-034 A store accepted on the edge where Rst=1 SHALL NOT occur (Req_ready=0 under reset).

Verification
REQ-035 Reset, DEPTH=64, INIT_ZERO=1 -> Req_ready low for exactly 64 cycles after Rst drops; a load at Addr 0xFC then returns 0x00000000.
REQ-036 sw 0x8899AABB to 0x10, then lb 0x10 / lbu 0x13 / lh 0x12 / lhu 0x10 -> 0xFFFFFFBB / 0x00000088 / 0xFFFF8899 / 0x0000AABB.
REQ-037 sw 0x11223344 to 0x20, sb 0xEE to 0x21, sh 0x5566 to 0x22, lw 0x20 -> 0x5566EE44.
REQ-038 sh to 0x31, lw to 0x22, Size=11 at 0x40 -> Err=1, Data_out=0, and a later lw of those words shows no change.
REQ-039 sw 0xCAFEF00D to 0x08 followed next cycle by lw 0x08 and lw 0x108 (DEPTH=64 alias) -> both return 0xCAFEF00D with Rsp_valid on consecutive cycles.
REQ-040 Rst pulsed at INIT word 30 -> sweep restarts at 0 and Req_ready rises 64 cycles after release; with INIT_ZERO=0, data written before reset survives it.

Source files
------------

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory: 32-bit words, byte/half/word loads and stores with
// alignment checking, a one-cycle response strobe and an optional zeroing sweep.
module data_mem_bytelane #(
  parameter int DEPTH     = 64,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req_valid,
  output logic        Req_ready,
  input  logic        Wr_en,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] Data_in,
  output logic        Rsp_valid,
  output logic [31:0] Data_out,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [0:0]    state;
  logic [AW-1:0] init_cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          accept;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_hi = ^Addr[31:AW+2];

  assign word_idx  = Addr[AW+1:2];
  assign lane      = Addr[1:0];
  assign Req_ready = (state == ST_RUN) && !Rst;
  assign accept    = Req_valid && Req_ready;
  assign rd_word   = mem[word_idx];
  assign rd_shift  = rd_word >> {lane, 3'b000};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    acc_err = 1'b0;
    be      = 4'b0000;
    wdata   = Data_in;
    ld_data = rd_shift;
    unique case (Size)
      SZ_BYTE: begin
        be      = 4'b0001 << lane;
        wdata   = {4{Data_in[7:0]}};
        ld_data = Unsigned ? {24'd0, rd_shift[7:0]}
                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_HALF: begin
        acc_err = lane[0];
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{Data_in[15:0]}};
        ld_data = Unsigned ? {16'd0, rd_shift[15:0]}
                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      SZ_WORD: begin
        acc_err = (lane != 2'b00);
        be      = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= INIT_ZERO ? ST_INIT : ST_RUN;
      init_cnt  <= '0;
      Rsp_valid <= 1'b0;
      Err       <= 1'b0;
      Data_out  <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
      end
      Rsp_valid <= accept;
      Err       <= accept && acc_err;
      if (accept) Data_out <= (!Wr_en && !acc_err) ? ld_data : 32'd0;
    end
  end

  // NOTE: the array itself has no reset; clearing is the sweep's job so the
  // storage can map onto RAM and survive reset when INIT_ZERO=0.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == ST_INIT) begin
        mem[init_cnt] <= '0;
      end else if (accept && Wr_en && !acc_err) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

endmodule
